// File: rtl/sparc_regfile_pkg.sv
// Shared register-file constants and the logical-to-physical register mapping.
package sparc_regfile_pkg;

    localparam int unsigned GLOBALS      = 8;
    localparam int unsigned REGS_PER_WIN = 16;
    localparam int unsigned OUTS         = 0;
    localparam int unsigned LOCALS       = 8;
    localparam int unsigned INS          = 16;

    // r0 maps one past the last physical line so a range-checked decoder drops it.
    function automatic int unsigned phys_index(input logic [4:0] addr,
                                               input int unsigned cwp,
                                               input int unsigned nwin);
        int unsigned span;
        int unsigned base;
        int unsigned s;
        span = REGS_PER_WIN * nwin;
        if (addr == 5'd0) begin
            return GLOBALS + span;
        end
        if (addr[4:3] == 2'd0) begin
            return 32'(addr);
        end
        unique case (addr[4:3])
            2'd1:    base = OUTS;
            2'd2:    base = LOCALS;
            default: base = INS;
        endcase
        s = REGS_PER_WIN * cwp + base + 32'(addr[2:0]);
        if (s >= span) begin
            s = s - span;
        end
        return GLOBALS + s;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational binary-to-one-hot decoder with enable; out-of-range inputs decode to zero.
module onehot_decoder #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 16
) (
    input  logic             en,
    input  logic [IN_W-1:0]  idx,
    output logic [OUT_W-1:0] dec_c
);

    always_comb begin
        dec_c = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (en && (idx == IN_W'(i))) begin
                dec_c[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_window_decoder.sv
// Windowed register-file write-select decoder; owns CWP/WIM and flags SAVE/RESTORE traps.
module reg_window_decoder
    import sparc_regfile_pkg::*;
#(
    parameter int unsigned NWIN = 8,
    parameter int unsigned CWPW = (NWIN > 1) ? $clog2(NWIN) : 1,
    parameter int unsigned PHYS = 8 + 16 * NWIN
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [4:0]      Addr,
    input  logic            Ld,
    input  logic            Save,
    input  logic            Restore,
    input  logic            CwpLd,
    input  logic [CWPW-1:0] CwpIn,
    input  logic            WimLd,
    input  logic [NWIN-1:0] WimIn,
    output logic [PHYS-1:0] Eout,
    output logic [CWPW-1:0] Cwp,
    output logic            TrapOvf,
    output logic            TrapUnf
);

    localparam int unsigned IDX_W = $clog2(PHYS + 1);

    logic [NWIN-1:0]  wim;
    logic [IDX_W-1:0] phys_idx;
    logic [PHYS-1:0]  eout_c;
    logic [CWPW-1:0]  cwp_dec;
    logic [CWPW-1:0]  cwp_inc;
    logic [CWPW-1:0]  cwp_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    assign phys_idx = IDX_W'(phys_index(Addr, 32'(Cwp), NWIN));

    onehot_decoder #(
        .IN_W  (IDX_W),
        .OUT_W (PHYS)
    ) u_dec (
        .en    (Ld),
        .idx   (phys_idx),
        .dec_c (eout_c)
    );

    // Neighbouring windows with explicit wrap so any NWIN works.
    assign cwp_dec = (Cwp == '0) ? CWPW'(NWIN - 1) : Cwp - 1'b1;
    assign cwp_inc = (Cwp == CWPW'(NWIN - 1)) ? '0 : Cwp + 1'b1;

    always_comb begin
        cwp_nxt = Cwp;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (CwpLd) begin
            cwp_nxt = CWPW'(32'(CwpIn) % NWIN);
        end else if (Save && Restore) begin
            cwp_nxt = Cwp;
        end else if (Save) begin
            if (wim[cwp_dec]) begin
                ovf_nxt = 1'b1;
            end else begin
                cwp_nxt = cwp_dec;
            end
        end else if (Restore) begin
            if (wim[cwp_inc]) begin
                unf_nxt = 1'b1;
            end else begin
                cwp_nxt = cwp_inc;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Eout    <= '0;
            Cwp     <= '0;
            wim     <= '0;
            TrapOvf <= 1'b0;
            TrapUnf <= 1'b0;
        end else begin
            Eout    <= eout_c;
            Cwp     <= cwp_nxt;
            TrapOvf <= ovf_nxt;
            TrapUnf <= unf_nxt;
            if (WimLd) begin
                wim <= WimIn;
            end
        end
    end

endmodule
